// File: rtl/bsg_print_stat_snoop_buffered_pkg.sv
// bsg_print_stat_snoop_buffered_pkg: shared packet op codes, print-stat address and link width helpers
package bsg_print_stat_snoop_buffered_pkg;
  typedef enum logic [1:0] {
    e_remote_load,
    e_remote_store,
    e_remote_masked_store,
    e_remote_amo
  } bsg_manycore_packet_op_e;
  localparam int bsg_print_stat_epa_gp = 'h300;
  function automatic int safe_clog2(input int n);
    return n <= 1 ? 1 : $clog2(n);
  endfunction
  function automatic int link_sif_width(input int a, input int d, input int x, input int y);
    return (1 + (a + 2 + d + 2 * (x + y)) + 1) + (1 + d + 1);
  endfunction
endpackage

// File: rtl/bsg_print_stat_snoop_buffered_fifo.sv
// bsg_print_stat_snoop_buffered_fifo: small one-read one-write record fifo with valid/yumi output
module bsg_print_stat_snoop_buffered_fifo #(
  parameter int width_p = 8,
  parameter int els_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);
  localparam int aw = $clog2(els_p);
  logic [width_p-1:0] mem [els_p];
  logic [aw:0] wp, rp;
  logic push;
  assign push = v_i && ready_o;
  assign v_o = wp != rp;
  assign ready_o = (wp ^ rp) != {1'b1, {aw{1'b0}}};
  assign data_o = mem[rp[aw-1:0]];
  always_ff @(posedge clk_i) begin
    wp <= reset_i ? '0 : push ? wp + 1'b1 : wp;
    rp <= reset_i ? '0 : yumi_i ? rp + 1'b1 : rp;
  end
  always_ff @(posedge clk_i) begin
    if (push) mem[wp[aw-1:0]] <= data_i;
  end
endmodule

// File: rtl/bsg_print_stat_snoop_buffered.sv
// bsg_print_stat_snoop_buffered: passive multi-channel print-stat snooper with timestamped record fifo
module bsg_print_stat_snoop_buffered
  import bsg_print_stat_snoop_buffered_pkg::*;
#(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 28,
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 4,
  parameter int num_chan_p = 4,
  parameter int base_addr_p = bsg_print_stat_epa_gp >> 2,
  parameter int els_p = 8,
  parameter int timer_width_p = 32,
  parameter int drop_width_p = 16,
  localparam int chan_width_lp = safe_clog2(num_chan_p),
  localparam int link_sif_width_lp = link_sif_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [link_sif_width_lp-1:0] loader_link_sif_in_i,
  input  logic [link_sif_width_lp-1:0] loader_link_sif_out_i,
  output logic                         v_o,
  output logic [chan_width_lp-1:0]     chan_o,
  output logic [data_width_p-1:0]      tag_o,
  output logic [x_cord_width_p-1:0]    src_x_o,
  output logic [y_cord_width_p-1:0]    src_y_o,
  output logic [timer_width_p-1:0]     time_o,
  input  logic                         yumi_i,
  output logic [drop_width_p-1:0]      drop_count_o,
  output logic                         overflow_o
);
  typedef struct packed {
    logic [addr_width_p-1:0]   addr;
    bsg_manycore_packet_op_e   op;
    logic [data_width_p-1:0]   payload;
    logic [y_cord_width_p-1:0] src_y;
    logic [x_cord_width_p-1:0] src_x;
    logic [y_cord_width_p-1:0] y_cord;
    logic [x_cord_width_p-1:0] x_cord;
  } packet_s;
  typedef struct packed {
    logic    v;
    packet_s data;
    logic    ready_and_rev;
  } fwd_s;
  typedef struct packed {
    logic                    v;
    logic [data_width_p-1:0] data;
    logic                    ready_and_rev;
  } rev_s;
  typedef struct packed {
    fwd_s fwd;
    rev_s rev;
  } link_sif_s;
  typedef struct packed {
    logic [chan_width_lp-1:0]  chan;
    logic [data_width_p-1:0]   tag;
    logic [x_cord_width_p-1:0] src_x;
    logic [y_cord_width_p-1:0] src_y;
    logic [timer_width_p-1:0]  stamp;
  } record_s;
  localparam logic [addr_width_p-1:0] base = addr_width_p'(base_addr_p);
  link_sif_s link_in, link_out;
  record_s rec_in, rec_out;
  logic [addr_width_p-1:0] offset;
  logic [timer_width_p-1:0] timer;
  logic hit, ready, unused;
  assign link_in = loader_link_sif_in_i;
  assign link_out = loader_link_sif_out_i;
  assign unused = ^{link_in, link_out};
  assign offset = link_in.fwd.data.addr - base;
  assign hit = link_in.fwd.v && link_out.fwd.ready_and_rev && link_in.fwd.data.op == e_remote_store
            && link_in.fwd.data.addr >= base && offset < addr_width_p'(num_chan_p);
  assign rec_in = '{chan: offset[chan_width_lp-1:0], tag: link_in.fwd.data.payload,
                    src_x: link_in.fwd.data.src_x, src_y: link_in.fwd.data.src_y, stamp: timer};
  always_ff @(posedge clk_i) begin
    timer <= reset_i ? '0 : timer + 1'b1;
    drop_count_o <= reset_i ? '0 : (hit && !ready && !(&drop_count_o)) ? drop_count_o + 1'b1 : drop_count_o;
    overflow_o <= reset_i ? 1'b0 : overflow_o || (hit && !ready);
  end
  bsg_print_stat_snoop_buffered_fifo #(
    .width_p($bits(record_s)),
    .els_p(els_p)
  ) fifo (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .v_i(hit),
    .ready_o(ready),
    .data_i(rec_in),
    .v_o(v_o),
    .data_o(rec_out),
    .yumi_i(yumi_i)
  );
  assign chan_o = rec_out.chan;
  assign tag_o = rec_out.tag;
  assign src_x_o = rec_out.src_x;
  assign src_y_o = rec_out.src_y;
  assign time_o = rec_out.stamp;
endmodule

// File: tb/tb_bsg_print_stat_snoop_buffered.sv
// tb_bsg_print_stat_snoop_buffered: scoreboard bench for the buffered print-stat snooper
module tb_bsg_print_stat_snoop_buffered;
  import bsg_print_stat_snoop_buffered_pkg::*;
  localparam int DW = 32, AW = 28, XW = 4, YW = 4, NC = 4, ELS = 8, TW = 4, DRW = 2, CW = 2;
  localparam logic [AW-1:0] BASE = 28'hC0;
  localparam int LW = link_sif_width(AW, DW, XW, YW);
  typedef struct packed {
    logic [AW-1:0] addr;
    bsg_manycore_packet_op_e op;
    logic [DW-1:0] payload;
    logic [YW-1:0] src_y;
    logic [XW-1:0] src_x;
    logic [YW-1:0] y_cord;
    logic [XW-1:0] x_cord;
  } packet_s;
  typedef struct packed { logic v; packet_s data; logic ready_and_rev; } fwd_s;
  typedef struct packed { logic v; logic [DW-1:0] data; logic ready_and_rev; } rev_s;
  typedef struct packed { fwd_s fwd; rev_s rev; } link_sif_s;
  typedef struct packed {
    logic [CW-1:0] chan;
    logic [DW-1:0] tag;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [TW-1:0] t;
  } exp_s;
  logic clk = 0, rst = 1, yumi = 0;
  link_sif_s lin = '0, lout = '0;
  logic v_o, overflow_o;
  logic [CW-1:0] chan_o;
  logic [DW-1:0] tag_o;
  logic [XW-1:0] src_x_o;
  logic [YW-1:0] src_y_o;
  logic [TW-1:0] time_o;
  logic [DRW-1:0] drop_count_o;
  logic [TW-1:0] tmodel;
  exp_s q[$];
  int vectors = 0, miscompares = 0, n;
  always #5 clk = ~clk;
  bsg_print_stat_snoop_buffered #(
    .data_width_p(DW), .addr_width_p(AW), .x_cord_width_p(XW), .y_cord_width_p(YW),
    .num_chan_p(NC), .base_addr_p(int'(BASE)), .els_p(ELS), .timer_width_p(TW), .drop_width_p(DRW)
  ) dut (
    .clk_i(clk),
    .reset_i(rst),
    .loader_link_sif_in_i(lin),
    .loader_link_sif_out_i(lout),
    .v_o(v_o),
    .chan_o(chan_o),
    .tag_o(tag_o),
    .src_x_o(src_x_o),
    .src_y_o(src_y_o),
    .time_o(time_o),
    .yumi_i(yumi),
    .drop_count_o(drop_count_o),
    .overflow_o(overflow_o)
  );
  always @(posedge clk) tmodel <= rst ? '0 : tmodel + 1'b1;
  always @(negedge clk) begin
    if (!rst) begin
      vectors++;
      if (v_o !== (q.size() != 0)) begin
        miscompares++;
        $display("FAIL v_o: got %b expected %b", v_o, q.size() != 0);
      end
      if (v_o && q.size() != 0) begin
        vectors++;
        if ({chan_o, tag_o, src_x_o, src_y_o, time_o} !== q[0]) begin
          miscompares++;
          $display("FAIL head: got chan=%0d tag=%h x=%0d y=%0d t=%0d expected chan=%0d tag=%h x=%0d y=%0d t=%0d",
                   chan_o, tag_o, src_x_o, src_y_o, time_o, q[0].chan, q[0].tag, q[0].x, q[0].y, q[0].t);
        end
        if (yumi) void'(q.pop_front());
      end else if (yumi) begin
        miscompares++;
        $display("FAIL illegal_pop: yumi_i with v_o=%b", v_o);
      end
    end
  end
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic drive(input bsg_manycore_packet_op_e op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [XW-1:0] sx, input logic [YW-1:0] sy, input logic rdy, input logic pop, input int t);
    logic h, full;
    logic [TW-1:0] ts;
    lin = '0;
    lin.fwd.v = 1'b1;
    lin.fwd.data.addr = a;
    lin.fwd.data.op = op;
    lin.fwd.data.payload = d;
    lin.fwd.data.src_x = sx;
    lin.fwd.data.src_y = sy;
    lout = '0;
    lout.fwd.ready_and_rev = rdy;
    yumi = pop;
    h = op == e_remote_store && rdy && a >= BASE && a < BASE + NC;
    full = q.size() == ELS;
    ts = t < 0 ? tmodel : TW'(t);
    @(posedge clk);
    if (h && !full) q.push_back('{CW'(a - BASE), d, sx, sy, ts});
    #1;
    lin = '0;
    lout = '0;
    yumi = 1'b0;
  endtask
  task automatic hit(input logic [DW-1:0] d, input logic pop, input int t);
    drive(e_remote_store, BASE + AW'(d[1:0]), d, 4'd2, 4'd5, 1'b1, pop, t);
  endtask
  task automatic drain(output int cnt);
    cnt = 0;
    for (int i = 0; i < 20 && v_o; i++) begin
      yumi = 1'b1;
      @(posedge clk);
      #1;
      yumi = 1'b0;
      cnt++;
    end
  endtask
  task automatic reset_pulse(input logic with_hit);
    rst = 1'b1;
    if (with_hit) begin
      lin.fwd.v = 1'b1;
      lin.fwd.data.addr = BASE;
      lin.fwd.data.op = e_remote_store;
      lout.fwd.ready_and_rev = 1'b1;
    end
    @(posedge clk);
    q.delete();
    #1;
    rst = 1'b0;
    lin = '0;
    lout = '0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_v", v_o, 0);
    check("reset_drop", drop_count_o, 0);
    check("reset_ovf", overflow_o, 0);
    idle(10);
    drive(e_remote_store, BASE + 2, 32'hDEAD, 4'd1, 4'd3, 1'b1, 1'b0, 10);
    check("single_v", v_o, 1);
    drain(n);
    check("single_pops", n, 1);
    drive(e_remote_store, BASE - 1, 32'h1, 4'd1, 4'd1, 1'b1, 1'b0, -1);
    drive(e_remote_store, BASE + NC, 32'h2, 4'd1, 4'd1, 1'b1, 1'b0, -1);
    drive(e_remote_load, BASE, 32'h3, 4'd1, 4'd1, 1'b1, 1'b0, -1);
    drive(e_remote_store, BASE, 32'h4, 4'd1, 4'd1, 1'b0, 1'b0, -1);
    idle(1);
    check("filter_v", v_o, 0);
    check("filter_drop", drop_count_o, 0);
    check("filter_ovf", overflow_o, 0);
    for (int i = 0; i < 10; i++) hit(DW'(i), 1'b0, -1);
    check("ovf_drop", drop_count_o, 2);
    check("ovf_flag", overflow_o, 1);
    drain(n);
    check("ovf_pops", n, 8);
    check("ovf_sticky", overflow_o, 1);
    for (int i = 0; i < 8; i++) hit(32'h10 + DW'(i), 1'b0, -1);
    hit(32'h55, 1'b1, -1);
    check("fullpop_drop", drop_count_o, 3);
    hit(32'h66, 1'b1, -1);
    check("fullpop_drop2", drop_count_o, 3);
    drain(n);
    check("fullpop_pops", n, 7);
    reset_pulse(1'b0);
    idle(17);
    hit(32'h17, 1'b0, 1);
    drain(n);
    check("wrap_pops", n, 1);
    for (int i = 0; i < 8; i++) hit(32'h20 + DW'(i), 1'b0, -1);
    hit(32'h30, 1'b0, -1);
    check("sat_drop1", drop_count_o, 1);
    for (int i = 0; i < 4; i++) hit(32'h31 + DW'(i), 1'b0, -1);
    check("sat_drop5", drop_count_o, 3);
    check("sat_ovf", overflow_o, 1);
    reset_pulse(1'b0);
    for (int i = 0; i < 3; i++) hit(32'h40 + DW'(i), 1'b0, -1);
    check("mid_v_before", v_o, 1);
    reset_pulse(1'b1);
    check("mid_v", v_o, 0);
    check("mid_drop", drop_count_o, 0);
    check("mid_ovf", overflow_o, 0);
    hit(32'hBEEF, 1'b0, 0);
    drain(n);
    check("mid_pops", n, 1);
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
